// File: rtl/decimation_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : decimation_scan_ctrl
//  Purpose  : Raster-order frame sequencer for the 2^SHIFT_FACTOR:1 decimator;
//             issues output coordinates and writes returned pixels linearly.
//  Revision : 1.0 - initial release
// ============================================================================
module decimation_scan_ctrl #(
  parameter int IMG_WIDTH_IN  = 160,
  parameter int IMG_HEIGHT_IN = 120,
  parameter int SHIFT_FACTOR  = 1,
  parameter int RAM_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [8:0]  x_out_coord,
  output logic [7:0]  y_out_coord,
  input  logic [7:0]  pixel_in,
  output logic [14:0] w_addr,
  output logic [7:0]  w_data,
  output logic        w_en,
  output logic        busy,
  output logic        done
);

  localparam int         c_OUT_W  = IMG_WIDTH_IN >> SHIFT_FACTOR;
  localparam int         c_OUT_H  = IMG_HEIGHT_IN >> SHIFT_FACTOR;
  localparam logic [8:0] c_X_LAST = 9'(c_OUT_W - 1);
  localparam logic [7:0] c_Y_LAST = 8'(c_OUT_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [8:0]             r_x;
  logic [7:0]             r_y;
  logic [RAM_LATENCY-1:0] r_vld;
  logic [14:0]            r_wr_cnt;
  logic [14:0]            r_w_addr;
  logic [7:0]             r_w_data;
  logic                   r_w_en;
  logic                   w_issue;
  logic                   w_tap;
  logic                   w_last_coord;

  assign w_issue      = (r_state == ST_SCAN);
  assign w_tap        = r_vld[RAM_LATENCY-1];
  assign w_last_coord = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start && !abort) w_next = ST_SCAN;
      ST_SCAN:  if (abort) w_next = ST_IDLE;
                else if (w_last_coord) w_next = ST_DRAIN;
      ST_DRAIN: if (abort) w_next = ST_IDLE;
                else if (r_vld == '0) w_next = ST_FIN;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Coordinates sit at zero outside SCAN so the address stage sees a stable input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_issue && !abort && !w_last_coord) begin
      if (r_x == c_X_LAST) begin
        r_x <= '0;
        r_y <= r_y + 8'd1;
      end else begin
        r_x <= r_x + 9'd1;
      end
    end else begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  generate
    if (RAM_LATENCY == 1) begin : g_vld_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vld <= '0;
        else        r_vld <= abort ? 1'b0 : w_issue;
      end
    end else begin : g_vld_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vld <= '0;
        else        r_vld <= abort ? '0 : {r_vld[RAM_LATENCY-2:0], w_issue};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_w_addr <= '0;
      r_w_data <= '0;
      r_w_en   <= 1'b0;
    end else begin
      r_w_en <= w_tap && !abort;
      if (r_state == ST_IDLE) begin
        r_wr_cnt <= '0;
      end else if (w_tap && !abort) begin
        r_w_addr <= r_wr_cnt;
        r_w_data <= pixel_in;
        r_wr_cnt <= r_wr_cnt + 15'd1;
      end
    end
  end

  assign x_out_coord = r_x;
  assign y_out_coord = r_y;
  assign w_addr      = r_w_addr;
  assign w_data      = r_w_data;
  assign w_en        = r_w_en;
  assign busy        = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
  assign done        = (r_state == ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_decimation_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decimation_scan_ctrl
//  Purpose  : Runs latency-1 and latency-3 controllers side by side against a
//             cycle-indexed model of the frame schedule and pixel contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decimation_scan_ctrl;

  localparam int IW = 160;
  localparam int IH = 120;
  localparam int S  = 1;
  localparam int OW = IW >> S;
  localparam int OH = IH >> S;
  localparam int N  = OW * OH;
  localparam int LAST_C = N + 3 + 4;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  always #5 clk = ~clk;

  logic [8:0]  x1, x3;
  logic [7:0]  y1, y3, pix1, pix3, wd1, wd3, p3a, p3b;
  logic [14:0] wa1, wa3;
  logic        we1, we3, b1, b3, d1, d3;

  int n_tests = 0;
  int n_fail  = 0;

  decimation_scan_ctrl #(.IMG_WIDTH_IN(IW), .IMG_HEIGHT_IN(IH), .SHIFT_FACTOR(S), .RAM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_out_coord(x1), .y_out_coord(y1), .pixel_in(pix1),
    .w_addr(wa1), .w_data(wd1), .w_en(we1), .busy(b1), .done(d1));

  decimation_scan_ctrl #(.IMG_WIDTH_IN(IW), .IMG_HEIGHT_IN(IH), .SHIFT_FACTOR(S), .RAM_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_out_coord(x3), .y_out_coord(y3), .pixel_in(pix3),
    .w_addr(wa3), .w_data(wd3), .w_en(we3), .busy(b3), .done(d3));

  // Input frame RAM holds pixel = addr[7:0]; the decimation stage picks (x<<S, y<<S).
  function automatic logic [7:0] ram_rd(input logic [8:0] x, input logic [7:0] y);
    int a;
    a = ((int'(y) << S) * IW) + (int'(x) << S);
    return a[7:0];
  endfunction

  always @(posedge clk) pix1 <= ram_rd(x1, y1);
  always @(posedge clk) begin
    p3a  <= ram_rd(x3, y3);
    p3b  <= p3a;
    pix3 <= p3b;
  end

  function automatic int exp_data(input int i);
    return ((2 * (i / OW) * IW) + 2 * (i % OW)) & 255;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs in cycle c after START (abort_at=0 means no abort).
  task automatic check_dut(input int lat, input int c, input int abort_at,
                           input logic [8:0] x, input logic [7:0] y, input logic [14:0] wa,
                           input logic [7:0] wd, input logic we, input logic b, input logic d);
    bit aborted;
    int ex, ey, i;
    bit exp_we, skip_we;
    aborted = (abort_at > 0) && (c > abort_at);
    ex = 0; ey = 0;
    if (!aborted && c >= 1 && c <= N) begin
      ex = (c - 1) % OW;
      ey = (c - 1) / OW;
    end
    check($sformatf("L%0d_x@%0d", lat, c), int'(x), ex);
    check($sformatf("L%0d_y@%0d", lat, c), int'(y), ey);
    skip_we = aborted && (c <= abort_at + lat + 1);
    exp_we  = !aborted && (c >= lat + 2) && (c <= N + lat + 1);
    if (!skip_we) check($sformatf("L%0d_wen@%0d", lat, c), int'(we), int'(exp_we));
    if (exp_we) begin
      i = c - lat - 2;
      check($sformatf("L%0d_waddr@%0d", lat, c), int'(wa), i);
      check($sformatf("L%0d_wdata@%0d", lat, c), int'(wd), exp_data(i));
    end
    check($sformatf("L%0d_busy@%0d", lat, c), int'(b),
          int'(!aborted && c >= 1 && c <= N + lat + 1));
    check($sformatf("L%0d_done@%0d", lat, c), int'(d), int'(!aborted && c == N + lat + 2));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_L1_out"}, int'({x1, y1, wa1, wd1, we1, b1, d1} != '0), 0);
    check({tag, "_L3_out"}, int'({x3, y3, wa3, wd3, we3, b3, d3} != '0), 0);
  endtask

  // Called at a negedge; START is sampled at the following edge (edge 0).
  task automatic run_frame(input int abort_at, input int rst_at,
                           input int g1, input int g2, input int g3, input int fin_start);
    int last;
    last = (abort_at > 0) ? abort_at + 10 : LAST_C;
    start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (3) @(negedge clk);
        check_zero("held_rst");
        rst_n = 1'b1;
        return;
      end
      check_dut(1, c, abort_at, x1, y1, wa1, wd1, we1, b1, d1);
      check_dut(3, c, abort_at, x3, y3, wa3, wd3, we3, b3, d3);
      start = (c == g1) || (c == g2) || (c == g3) || (c == fin_start);
      abort = (c == abort_at);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 5)) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 0, 0, 0, 0, 0);
    idle_gap();
    run_frame(0, 0, 10, 2000, $urandom_range(3, N), N + 3);
    idle_gap();
    run_frame(500, 0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 0);
    idle_gap();

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort_wins_busy_L1_%0d", k), int'(b1), 0);
      check($sformatf("abort_wins_busy_L3_%0d", k), int'(b3), 0);
      @(negedge clk);
    end

    run_frame($urandom_range(100, N), 0, 0, 0, 0, 0);
    idle_gap();
    run_frame(0, 1000, 0, 0, 0, 0);
    idle_gap();
    run_frame(0, 0, $urandom_range(3, N), 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decimation_scan_ctrl.md
# decimation_scan_ctrl

Frame sequencer for the 2:1 (generally 2^SHIFT_FACTOR:1) decimation path. On a START pulse it walks every output coordinate in raster order and drives X_OUT_COORD/Y_OUT_COORD into the combinational decimation address stage. That stage converts them to a read address for the synchronous input frame RAM. The controller then captures the returned pixel after the RAM read latency and writes it, with a linear address, into the output frame buffer.

## Interface
Parameters:
- IMG_WIDTH_IN, 160, input frame width in pixels
- IMG_HEIGHT_IN, 120, input frame height in pixels
- SHIFT_FACTOR, 1, log2 of decimation factor; OUT_W = IMG_WIDTH_IN >> SHIFT_FACTOR, OUT_H = IMG_HEIGHT_IN >> SHIFT_FACTOR
- RAM_LATENCY, 1, cycles from coordinate issue to valid PIXEL_IN (≥1)

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle request to process one frame; honoured only in IDLE
- ABORT  in  1  synchronous frame cancel
- X_OUT_COORD  out  9  output column to the decimation stage
- Y_OUT_COORD  out  8  output row to the decimation stage
- PIXEL_IN  in  8  decimated pixel (decimation stage PIXEL_OUT), valid RAM_LATENCY cycles after coordinate issue
- W_ADDR  out  15  output buffer write address = y*OUT_W + x
- W_DATA  out  8  output buffer write data
- W_EN  out  1  output buffer write strobe, one pixel per cycle high
- BUSY  out  1  high from first SCAN cycle through last W_EN cycle
- DONE  out  1  one-cycle pulse after the final write of a completed frame

## Operation
- States: IDLE, SCAN, DRAIN, FIN.
- IDLE: coords held at 0. START=1 and ABORT=0 → SCAN with x=0, y=0.
- SCAN: one coordinate issued per cycle. x increments; at x=OUT_W-1, x→0 and y increments. Issuing (OUT_W-1, OUT_H-1) → DRAIN; coords then hold at 0.
- Issue-valid shift register, RAM_LATENCY deep, tracks outstanding reads. When a tap emerges, PIXEL_IN is registered into W_DATA, W_EN=1 the following cycle, and W_ADDR is taken from a write counter starting at 0 and incrementing per write.
- DRAIN: wait until the valid pipeline is empty and the final W_EN cycle has completed → FIN.
- FIN: DONE=1 for exactly one cycle → IDLE. START in FIN is ignored.
- START while BUSY is ignored; no restart, no counter disturbance.
- ABORT (any non-IDLE state): next state IDLE, valid pipeline cleared, no further W_EN, no DONE. ABORT and START in the same IDLE cycle: ABORT wins, remain IDLE.
- Widths: coordinate counters sized to port widths; W_ADDR 15 bits (max OUT_W*OUT_H-1 = 4799 at defaults); no wrap within a frame.
- RST_N low: immediate return to IDLE. All outputs 0: coords, W_ADDR, W_DATA, W_EN, BUSY, DONE. Pipeline cleared.

## Timing
- RAM_LATENCY=L, N=OUT_W*OUT_H. START sampled at edge 0. Pixel k (0-based) has coords valid in cycle k+1, PIXEL_IN sampled at the end of cycle k+1+L, W_EN high in cycle k+2+L.
- Defaults (L=1, N=4800): writes in cycles 3..4802, BUSY cycles 1..4802, DONE cycle 4803, IDLE from cycle 4804. Sustained throughput 1 pixel/clock.
- W_ADDR, W_DATA, W_EN are registered outputs changing only on CLK rise, except on asynchronous reset.

## Test plan
- Full frame, defaults: input RAM loaded with pixel = addr[7:0]. Required: exactly 4800 W_EN pulses; write i has W_ADDR=i and W_DATA = (2*(i/80)*160 + 2*(i%80))[7:0]; DONE single pulse in cycle 4803.
- Row wrap: watch cycles 80–81 after START. Coords go (79,0) → (0,1); write 80 lands at W_ADDR=80 with data from input address 320.
- START pulsed at cycles 10 and 2000 of an active frame → no effect; 4800 writes and one DONE.
- ABORT in cycle 500 → W_EN stops within L+1 cycles, BUSY=0, no DONE. A following START yields a complete frame starting at W_ADDR=0.
- RST_N low in cycle 1000 → all outputs 0 immediately. After release, a new START produces a full correct frame.
- RAM_LATENCY=3 with a 3-stage RAM model → first W_EN in cycle 5, DONE in cycle 4805, data identical to the default case.
